// File: rtl/ntt_pkg.sv
// ----------------------------------------------------------------------------
// ntt_pkg
// Shared constants and types for the radix-8 NTT datapath.
//   N        : coefficient / twiddle width in bits
//   Q        : prime modulus (every coefficient and twiddle is < Q)
//   coef_t   : one N-bit residue
//   frame_t  : an 8-point frame, coefficients a[0..7] and twiddles tf[1..7]
//   state_t  : loader state (LOAD = collecting, FULL = frame presented)
// ----------------------------------------------------------------------------
package ntt_pkg;

   localparam int N = 17;
   localparam int Q = 65537;

   typedef logic [N-1:0] coef_t;

   typedef struct packed {
      coef_t [7:0] a;
      coef_t [7:1] tf;
   } frame_t;

   typedef enum logic {
      LOAD = 1'b0,
      FULL = 1'b1
   } state_t;

endpackage

// File: rtl/radix_8_ntt_loader_mod_mul.sv
// ----------------------------------------------------------------------------
// mod_mul
// Combinational modular multiply r = (x * y) mod Q. The full 2N-bit product
// is formed first, then reduced, so the result is exact for any x, y < Q.
// Also used by the butterfly stages downstream.
//   x, y : N-bit operands, each < Q
//   r    : N-bit result, < Q
// ----------------------------------------------------------------------------
module mod_mul #(
   parameter int N = 17,
   parameter int Q = 65537
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   output logic [N-1:0] r
);

   localparam logic [2*N-1:0] QW = (2*N)'(Q);

   logic [2*N-1:0] prod;

   assign prod = {{N{1'b0}}, x} * {{N{1'b0}}, y};
   // The remainder is < Q < 2^N, so dropping the upper half loses nothing.
   assign r    = N'(prod % QW);

endmodule

// File: rtl/radix_8_ntt_loader.sv
// ----------------------------------------------------------------------------
// radix_8_ntt_loader
// Packs a serial coefficient stream into a registered 8-point frame for the
// radix-8 DIT butterfly, and builds the twiddles tf_k = w^k mod Q one power
// per accepted coefficient while the frame loads.
//   clk, rst         : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready: coefficient handshake (accept = in_valid && in_ready)
//   in_data          : coefficient, < Q
//   in_tw            : base twiddle w, sampled on the first accept of a frame
//   out_valid/out_ready : frame handshake towards the butterfly
//   a0..a7           : frame coefficients, a_k = k-th accepted coefficient
//   tf1..tf7         : twiddles, tf_k = w^k mod Q
// ----------------------------------------------------------------------------
module radix_8_ntt_loader
   import ntt_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic [N-1:0] in_tw,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] a0,
   output logic [N-1:0] a1,
   output logic [N-1:0] a2,
   output logic [N-1:0] a3,
   output logic [N-1:0] a4,
   output logic [N-1:0] a5,
   output logic [N-1:0] a6,
   output logic [N-1:0] a7,
   output logic [N-1:0] tf1,
   output logic [N-1:0] tf2,
   output logic [N-1:0] tf3,
   output logic [N-1:0] tf4,
   output logic [N-1:0] tf5,
   output logic [N-1:0] tf6,
   output logic [N-1:0] tf7
);

   state_t     state;
   logic [2:0] count;
   coef_t      w_reg;
   frame_t     frm;
   coef_t      tf_cur;
   coef_t      tf_next;
   logic       accept;

   assign accept = in_valid && in_ready;

   // Previous power of w: on the accept with count=k, tf_k times w gives
   // tf_{k+1}. Only counts 1..6 produce a new power.
   // NOTE: every always_comb output gets a default first so that an
   // unlisted case value cannot leave it holding a value (a latch).
   always_comb begin
      tf_cur = '0;
      case (count)
         3'd1:    tf_cur = frm.tf[1];
         3'd2:    tf_cur = frm.tf[2];
         3'd3:    tf_cur = frm.tf[3];
         3'd4:    tf_cur = frm.tf[4];
         3'd5:    tf_cur = frm.tf[5];
         3'd6:    tf_cur = frm.tf[6];
         default: tf_cur = '0;
      endcase
   end

   mod_mul #(
      .N (N),
      .Q (Q)
   ) u_mod_mul (
      .x (tf_cur),
      .y (w_reg),
      .r (tf_next)
   );

   // in_ready / out_valid are kept as their own flops, updated together
   // with state, so the handshake outputs come straight from registers.
   // NOTE: all state here uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the frame registers are reset too -- the butterfly sees
         // all-zero operands after reset, not leftovers of a partial frame.
         state     <= LOAD;
         count     <= '0;
         w_reg     <= '0;
         frm       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (accept) begin
                  frm.a[count] <= in_data;
                  count        <= count + 3'd1;   // 7 wraps to 0
                  if (count == 3'd0) begin
                     w_reg     <= in_tw;
                     frm.tf[1] <= in_tw;
                  end else if (count != 3'd7) begin
                     frm.tf[count + 3'd1] <= tf_next;
                  end
                  if (count == 3'd7) begin
                     state     <= FULL;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            FULL: begin
               // No reload in the handshake cycle: in_ready returns on the
               // following cycle.
               if (out_ready) begin
                  state     <= LOAD;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= LOAD;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign a0  = frm.a[0];
   assign a1  = frm.a[1];
   assign a2  = frm.a[2];
   assign a3  = frm.a[3];
   assign a4  = frm.a[4];
   assign a5  = frm.a[5];
   assign a6  = frm.a[6];
   assign a7  = frm.a[7];
   assign tf1 = frm.tf[1];
   assign tf2 = frm.tf[2];
   assign tf3 = frm.tf[3];
   assign tf4 = frm.tf[4];
   assign tf5 = frm.tf[5];
   assign tf6 = frm.tf[6];
   assign tf7 = frm.tf[7];

endmodule

// File: tb/tb_radix_8_ntt_loader.sv
// ----------------------------------------------------------------------------
// tb_radix_8_ntt_loader
// Self-checking bench for radix_8_ntt_loader. A frame-level model collects
// accepted coefficients and computes the twiddle powers directly; a negedge
// compare process checks handshakes every cycle and the whole frame whenever
// one is presented. Hand-computed frames pin the model.
// ----------------------------------------------------------------------------
module tb_radix_8_ntt_loader;
   import ntt_pkg::*;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   logic  in_valid = 1'b0;
   logic  out_ready = 1'b0;
   coef_t in_data = '0;
   coef_t in_tw = '0;
   logic  in_ready, out_valid;
   coef_t a0, a1, a2, a3, a4, a5, a6, a7;
   coef_t tf1, tf2, tf3, tf4, tf5, tf6, tf7;

   radix_8_ntt_loader dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_tw     (in_tw),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a0 (a0), .a1 (a1), .a2 (a2), .a3 (a3),
      .a4 (a4), .a5 (a5), .a6 (a6), .a7 (a7),
      .tf1 (tf1), .tf2 (tf2), .tf3 (tf3), .tf4 (tf4),
      .tf5 (tf5), .tf6 (tf6), .tf7 (tf7)
   );

   always #5 clk = ~clk;

   coef_t da [8];
   coef_t dtf[8];
   always_comb begin
      da[0] = a0; da[1] = a1; da[2] = a2; da[3] = a3;
      da[4] = a4; da[5] = a5; da[6] = a6; da[7] = a7;
      dtf[0] = '0;
      dtf[1] = tf1; dtf[2] = tf2; dtf[3] = tf3; dtf[4] = tf4;
      dtf[5] = tf5; dtf[6] = tf6; dtf[7] = tf7;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   bit     m_full = 1'b0;
   int     m_n = 0;
   longint m_w = 0;
   longint m_buf[8];
   longint m_a[8];
   longint m_tf[8];
   longint m_p;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_full = 1'b0;
         m_n    = 0;
      end else if (!m_full) begin
         if (in_valid) begin
            if (m_n == 0) m_w = in_tw;
            m_buf[m_n] = in_data;
            m_n++;
            if (m_n == 8) begin
               m_full = 1'b1;
               m_n    = 0;
               for (int k = 0; k < 8; k++) m_a[k] = m_buf[k];
               m_p = 1;
               for (int k = 1; k < 8; k++) begin
                  m_p     = (m_p * m_w) % Q;
                  m_tf[k] = m_p;
               end
            end
         end
      end else if (out_ready) begin
         m_full = 1'b0;
      end
   end

   // ---------------- per-cycle compare ----------------
   bit chk_en = 1'b0;

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("in_ready", in_ready, !m_full);
         check("out_valid", out_valid, m_full);
         if (m_full) begin
            for (int k = 0; k < 8; k++) check($sformatf("a%0d", k), da[k], m_a[k]);
            for (int k = 1; k < 8; k++) check($sformatf("tf%0d", k), dtf[k], m_tf[k]);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_frame(input longint d[8], input longint tw, input int bubble_pct,
                             input int nbeats, input bit rand_or);
      int i = 0;
      int guard = 0;
      bit acc;
      while (i < nbeats) begin
         if (guard > 2000) begin
            check("send_timeout", i, nbeats);
            break;
         end
         guard++;
         if (rand_or) out_ready = ($urandom_range(99) < 60);
         in_valid = ($urandom_range(99) >= bubble_pct);
         in_data  = in_valid ? coef_t'(d[i]) : coef_t'($urandom_range(Q - 1));
         in_tw    = (i == 0) ? coef_t'(tw) : coef_t'($urandom_range(Q - 1));
         acc      = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) i++;
      end
      in_valid = 1'b0;
   endtask

   task automatic check_lit(input string tag, input longint ea[8], input longint etf[8]);
      check({tag, "_valid"}, out_valid, 1);
      for (int k = 0; k < 8; k++) check($sformatf("%s_a%0d", tag, k), da[k], ea[k]);
      for (int k = 1; k < 8; k++) check($sformatf("%s_tf%0d", tag, k), dtf[k], etf[k]);
   endtask

   // ---------------- test sequence ----------------
   longint d_seq[8]  = '{1, 2, 3, 4, 5, 6, 7, 8};
   longint d_alt[8]  = '{65536, 0, 100, 65535, 7, 12345, 1, 40000};
   longint tf_3[8]   = '{0, 3, 9, 27, 81, 243, 729, 2187};
   longint tf_m1[8]  = '{0, 65536, 1, 65536, 1, 65536, 1, 65536};
   longint tf_4k[8]  = '{0, 4096, 65281, 16, 65536, 61441, 256, 65521};
   longint d_rnd[8];
   longint snap[8];

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      for (int k = 0; k < 8; k++) check($sformatf("rst_a%0d", k), da[k], 0);
      for (int k = 1; k < 8; k++) check($sformatf("rst_tf%0d", k), dtf[k], 0);
      #2 rst = 1'b0;
      chk_en    = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;

      // Gapless powers of 3; valid must be a single-cycle pulse.
      send_frame(d_seq, 3, 0, 8, 1'b0);
      check_lit("pow3", d_seq, tf_3);
      @(posedge clk); #1;
      check("pulse_fall", out_valid, 0);
      check("ready_back", in_ready, 1);

      // w = -1 and w = 2^12 (exercise the modular wrap).
      send_frame(d_alt, 65536, 0, 8, 1'b0);
      check_lit("negone", d_alt, tf_m1);
      @(posedge clk); #1;
      send_frame(d_seq, 4096, 0, 8, 1'b0);
      check_lit("pow4096", d_seq, tf_4k);
      @(posedge clk); #1;

      // Back-pressure: frame held for 20 cycles while in_valid is driven.
      out_ready = 1'b0;
      for (int k = 0; k < 8; k++) d_rnd[k] = $urandom_range(Q - 1);
      send_frame(d_rnd, $urandom_range(Q - 1), 30, 8, 1'b0);
      for (int k = 0; k < 8; k++) snap[k] = da[k];
      in_valid = 1'b1;
      in_data  = 17'd99;
      repeat (20) begin
         @(posedge clk); #1;
         check("hold_in_ready", in_ready, 0);
         check("hold_a0", a0, snap[0]);
         check("hold_a7", a7, snap[7]);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_in_ready", in_ready, 1);
      check("release_out_valid", out_valid, 0);

      // Bubbles inside a frame must give the gapless result.
      send_frame(d_seq, 3, 40, 8, 1'b0);
      check_lit("bubble_pow3", d_seq, tf_3);
      @(posedge clk); #1;

      // Random frames, random bubbles, random back-pressure.
      for (int f = 0; f < 20; f++) begin
         for (int k = 0; k < 8; k++) d_rnd[k] = $urandom_range(Q - 1);
         send_frame(d_rnd, $urandom_range(Q - 1), 25, 8, 1'b1);
      end
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Async reset after 5 accepts, then a fresh frame.
      send_frame(d_alt, 3, 0, 5, 1'b0);
      #3 rst = 1'b1;
      #1;
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_out_valid", out_valid, 0);
      for (int k = 0; k < 8; k++) check($sformatf("mid_rst_a%0d", k), da[k], 0);
      for (int k = 1; k < 8; k++) check($sformatf("mid_rst_tf%0d", k), dtf[k], 0);
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      send_frame(d_seq, 4096, 20, 8, 1'b0);
      check_lit("post_rst", d_seq, tf_4k);
      @(posedge clk); #1;

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
